// File: rtl/bcd_counter_ndigit.sv
// rtl/bcd_counter_ndigit.sv - parametrised N-digit BCD up/down counter with clear, load, saturate/wrap
module bcd_counter_ndigit #(
  parameter int NDIGITS = 2,
  parameter bit WRAP    = 1'b0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   inc,
  input  logic                   dec,
  input  logic                   clr,
  input  logic                   load,
  input  logic [4*NDIGITS-1:0]   load_val,
  output logic [4*NDIGITS-1:0]   bcd,
  output logic                   at_max,
  output logic                   at_min,
  output logic                   ovf,
  output logic                   unf
);

  localparam int W = 4 * NDIGITS;

  logic [W-1:0]       r_bcd;
  logic               r_ovf;
  logic               r_unf;

  logic [NDIGITS-1:0] w_is9;
  logic [NDIGITS-1:0] w_is0;
  logic [NDIGITS:0]   w_carry;
  logic [NDIGITS:0]   w_borrow;
  logic [W-1:0]       w_inc_val;
  logic [W-1:0]       w_dec_val;
  logic [W-1:0]       w_load_clamped;
  logic               w_ovf_evt;
  logic               w_unf_evt;

  // Digit 0 always receives the step; higher digits only see it through the chain.
  assign w_carry[0]  = 1'b1;
  assign w_borrow[0] = 1'b1;

  genvar g;
  generate
    for (g = 0; g < NDIGITS; g++) begin : g_digit
      logic [3:0] w_dig;
      logic [3:0] w_ld;
      assign w_dig = r_bcd[4*g +: 4];
      assign w_ld  = load_val[4*g +: 4];

      assign w_is9[g] = (w_dig == 4'd9);
      assign w_is0[g] = (w_dig == 4'd0);

      // A digit passes carry/borrow upward only when it rolls over itself.
      assign w_carry[g+1]  = w_carry[g]  & w_is9[g];
      assign w_borrow[g+1] = w_borrow[g] & w_is0[g];

      assign w_inc_val[4*g +: 4] = !w_carry[g]  ? w_dig :
                                   (w_is9[g] ? 4'd0 : w_dig + 4'd1);
      assign w_dec_val[4*g +: 4] = !w_borrow[g] ? w_dig :
                                   (w_is0[g] ? 4'd9 : w_dig - 4'd1);

      // Out-of-range nibbles (A-F) are clamped so no illegal code is stored.
      assign w_load_clamped[4*g +: 4] = (w_ld > 4'd9) ? 4'd9 : w_ld;
    end
  endgenerate

  assign w_ovf_evt = w_carry[NDIGITS];
  assign w_unf_evt = w_borrow[NDIGITS];

  // Count register and boundary pulses; clr beats load beats a single inc/dec.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_bcd <= '0;
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else begin
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
      if (clr) begin
        r_bcd <= '0;
      end else if (load) begin
        r_bcd <= w_load_clamped;
      end else if (inc && !dec) begin
        // On overflow the chain has already produced all zeros, which is the wrap result.
        if (WRAP || !w_ovf_evt) r_bcd <= w_inc_val;
        r_ovf <= w_ovf_evt;
      end else if (dec && !inc) begin
        // On underflow the chain has already produced all nines, which is the wrap result.
        if (WRAP || !w_unf_evt) r_bcd <= w_dec_val;
        r_unf <= w_unf_evt;
      end
    end
  end

  assign bcd    = r_bcd;
  assign ovf    = r_ovf;
  assign unf    = r_unf;
  assign at_max = &w_is9;
  assign at_min = &w_is0;

endmodule

// File: tb/tb_bcd_counter_ndigit.sv
// tb/tb_bcd_counter_ndigit.sv - directed self-checking bench for bcd_counter_ndigit
module tb_bcd_counter_ndigit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // 2-digit saturating instance
  logic        inc2 = 0, dec2 = 0, clr2 = 0, load2 = 0;
  logic [7:0]  lv2 = '0, bcd2;
  logic        max2, min2, ovf2, unf2;
  // 4-digit saturating instance
  logic        inc4 = 0, dec4 = 0, clr4 = 0, load4 = 0;
  logic [15:0] lv4 = '0, bcd4;
  logic        max4, min4, ovf4, unf4;
  // 3-digit wrapping instance
  logic        inc3 = 0, dec3 = 0, clr3 = 0, load3 = 0;
  logic [11:0] lv3 = '0, bcd3;
  logic        max3, min3, ovf3, unf3;

  bcd_counter_ndigit #(.NDIGITS(2), .WRAP(1'b0)) u2 (
    .clk(clk), .reset(rst), .inc(inc2), .dec(dec2), .clr(clr2), .load(load2),
    .load_val(lv2), .bcd(bcd2), .at_max(max2), .at_min(min2), .ovf(ovf2), .unf(unf2));
  bcd_counter_ndigit #(.NDIGITS(4), .WRAP(1'b0)) u4 (
    .clk(clk), .reset(rst), .inc(inc4), .dec(dec4), .clr(clr4), .load(load4),
    .load_val(lv4), .bcd(bcd4), .at_max(max4), .at_min(min4), .ovf(ovf4), .unf(unf4));
  bcd_counter_ndigit #(.NDIGITS(3), .WRAP(1'b1)) u3 (
    .clk(clk), .reset(rst), .inc(inc3), .dec(dec3), .clr(clr3), .load(load3),
    .load_val(lv3), .bcd(bcd3), .at_max(max3), .at_min(min3), .ovf(ovf3), .unf(unf3));

  // One clock of requests on each instance; returns 1 time unit after the edge.
  task automatic cyc2(input logic c, input logic l, input logic i, input logic d, input logic [7:0] v);
    clr2 = c; load2 = l; inc2 = i; dec2 = d; lv2 = v;
    @(posedge clk); #1;
    clr2 = 0; load2 = 0; inc2 = 0; dec2 = 0;
  endtask

  task automatic cyc4(input logic c, input logic l, input logic i, input logic d, input logic [15:0] v);
    clr4 = c; load4 = l; inc4 = i; dec4 = d; lv4 = v;
    @(posedge clk); #1;
    clr4 = 0; load4 = 0; inc4 = 0; dec4 = 0;
  endtask

  task automatic cyc3(input logic c, input logic l, input logic i, input logic d, input logic [11:0] v);
    clr3 = c; load3 = l; inc3 = i; dec3 = d; lv3 = v;
    @(posedge clk); #1;
    clr3 = 0; load3 = 0; inc3 = 0; dec3 = 0;
  endtask

  task automatic test_reset;
    int ovf_seen;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (bcd2 !== 8'h00) begin n_err++; $display("FAIL reset_bcd: got %h expected 00", bcd2); end
    n_cmp++; if ({max2, min2, ovf2, unf2} !== 4'b0100) begin n_err++; $display("FAIL reset_flags: got max/min/ovf/unf=%b expected 0100", {max2, min2, ovf2, unf2}); end
    @(negedge clk); rst = 1'b0;
    // Held inc counts once per cycle: 37 cycles -> 37
    inc2 = 1'b1;
    repeat (37) @(posedge clk);
    #1; inc2 = 1'b0;
    n_cmp++; if (bcd2 !== 8'h37) begin n_err++; $display("FAIL count_to_37: got %h expected 37", bcd2); end
    // Asynchronous reset mid-count, checked before any further edge
    #2; rst = 1'b1; #1;
    n_cmp++; if (bcd2 !== 8'h00 || min2 !== 1'b1) begin n_err++; $display("FAIL async_reset: got bcd=%h at_min=%b expected 00/1", bcd2, min2); end
    @(negedge clk); rst = 1'b0;
    ovf_seen = 0;
    for (int k = 0; k < 12; k++) begin
      cyc2(0, 0, 1, 0, 8'h00);
      if (ovf2 !== 1'b0) ovf_seen++;
      cyc2(0, 0, 0, 0, 8'h00);
    end
    n_cmp++; if (bcd2 !== 8'h12) begin n_err++; $display("FAIL twelve_incs: got %h expected 12", bcd2); end
    n_cmp++; if (ovf_seen !== 0) begin n_err++; $display("FAIL twelve_incs_ovf: got %0d ovf cycles expected 0", ovf_seen); end
  endtask

  task automatic test_carry_borrow;
    cyc4(0, 1, 0, 0, 16'h0999);
    cyc4(0, 0, 1, 0, 16'h0000);
    n_cmp++; if (bcd4 !== 16'h1000 || ovf4 !== 1'b0) begin n_err++; $display("FAIL carry_0999: got %h ovf=%b expected 1000/0", bcd4, ovf4); end
    cyc4(0, 0, 0, 1, 16'h0000);
    n_cmp++; if (bcd4 !== 16'h0999 || unf4 !== 1'b0) begin n_err++; $display("FAIL borrow_1000a: got %h unf=%b expected 0999/0", bcd4, unf4); end
    cyc4(0, 1, 0, 0, 16'h1000);
    cyc4(0, 0, 0, 1, 16'h0000);
    n_cmp++; if (bcd4 !== 16'h0999 || {ovf4, unf4} !== 2'b00) begin n_err++; $display("FAIL borrow_1000b: got %h ovf/unf=%b expected 0999/00", bcd4, {ovf4, unf4}); end
  endtask

  task automatic test_back_to_back;
    cyc4(0, 1, 0, 0, 16'h0098);
    inc4 = 1'b1;
    repeat (3) @(posedge clk);
    #1; inc4 = 1'b0;
    n_cmp++; if (bcd4 !== 16'h0101) begin n_err++; $display("FAIL held_inc: got %h expected 0101", bcd4); end
  endtask

  task automatic test_saturation;
    cyc2(0, 1, 0, 0, 8'h99);
    cyc2(0, 0, 1, 0, 8'h00);
    n_cmp++; if (bcd2 !== 8'h99 || ovf2 !== 1'b1 || max2 !== 1'b1) begin n_err++; $display("FAIL sat_max: got bcd=%h ovf=%b at_max=%b expected 99/1/1", bcd2, ovf2, max2); end
    cyc2(0, 0, 0, 0, 8'h00);
    n_cmp++; if (ovf2 !== 1'b0 || bcd2 !== 8'h99) begin n_err++; $display("FAIL sat_ovf_pulse: got ovf=%b bcd=%h expected 0/99", ovf2, bcd2); end
    cyc2(1, 0, 0, 0, 8'h00);
    cyc2(0, 0, 0, 1, 8'h00);
    n_cmp++; if (bcd2 !== 8'h00 || unf2 !== 1'b1 || min2 !== 1'b1) begin n_err++; $display("FAIL sat_min: got bcd=%h unf=%b at_min=%b expected 00/1/1", bcd2, unf2, min2); end
    cyc2(0, 0, 0, 0, 8'h00);
    n_cmp++; if (unf2 !== 1'b0) begin n_err++; $display("FAIL sat_unf_pulse: got %b expected 0", unf2); end
  endtask

  task automatic test_wrap;
    cyc3(0, 1, 0, 0, 12'h999);
    n_cmp++; if (max3 !== 1'b1) begin n_err++; $display("FAIL wrap_at_max: got %b expected 1", max3); end
    cyc3(0, 0, 1, 0, 12'h000);
    n_cmp++; if (bcd3 !== 12'h000 || ovf3 !== 1'b1 || unf3 !== 1'b0) begin n_err++; $display("FAIL wrap_inc: got %h ovf/unf=%b expected 000/10", bcd3, {ovf3, unf3}); end
    cyc3(0, 0, 0, 1, 12'h000);
    n_cmp++; if (bcd3 !== 12'h999 || unf3 !== 1'b1 || ovf3 !== 1'b0) begin n_err++; $display("FAIL wrap_dec: got %h ovf/unf=%b expected 999/01", bcd3, {ovf3, unf3}); end
  endtask

  task automatic test_priority;
    cyc2(0, 1, 0, 0, 8'h45);
    cyc2(0, 0, 1, 1, 8'h00);
    n_cmp++; if (bcd2 !== 8'h45 || {ovf2, unf2} !== 2'b00) begin n_err++; $display("FAIL inc_and_dec: got %h ovf/unf=%b expected 45/00", bcd2, {ovf2, unf2}); end
    cyc2(1, 1, 1, 0, 8'h77);
    n_cmp++; if (bcd2 !== 8'h00) begin n_err++; $display("FAIL clr_priority: got %h expected 00", bcd2); end
    cyc2(0, 1, 1, 0, 8'h77);
    n_cmp++; if (bcd2 !== 8'h77) begin n_err++; $display("FAIL load_priority: got %h expected 77", bcd2); end
  endtask

  task automatic test_clamp;
    cyc2(0, 1, 0, 0, 8'hB3);
    n_cmp++; if (bcd2 !== 8'h93) begin n_err++; $display("FAIL clamp_b3: got %h expected 93", bcd2); end
    cyc2(0, 1, 0, 0, 8'hFF);
    n_cmp++; if (bcd2 !== 8'h99 || max2 !== 1'b1) begin n_err++; $display("FAIL clamp_ff: got %h at_max=%b expected 99/1", bcd2, max2); end
    cyc2(0, 1, 0, 0, 8'h0A);
    n_cmp++; if (bcd2 !== 8'h09 || min2 !== 1'b0) begin n_err++; $display("FAIL clamp_0a: got %h at_min=%b expected 09/0", bcd2, min2); end
  endtask

  initial begin
    test_reset;
    test_carry_borrow;
    test_back_to_back;
    test_saturation;
    test_wrap;
    test_priority;
    test_clamp;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
